// File: rtl/alu_writeback.sv
// ALU result capture and register-file writeback sequencer.
// Optional flag outputs (flag_z, flag_n) enabled by defining WB_FLAGS_EN.
module alu_writeback #(
    parameter int RD_W = 4
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      instruction,
    input  logic [RD_W-1:0] rd,
    input  logic [31:0]     Z_high,
    input  logic [31:0]     Z_low,
    output logic            wr_en,
    output logic [1:0]      wr_dst,
    output logic [RD_W-1:0] wr_rd,
    output logic [31:0]     wr_data,
    input  logic            wr_ack,
`ifdef WB_FLAGS_EN
    output logic            flag_z,
    output logic            flag_n,
`endif
    output logic            drop,
    output logic            done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR_GPR = 2'd1,
        WR_LO  = 2'd2,
        WR_HI  = 2'd3
    } state_t;

    localparam logic [1:0] DST_GPR = 2'b00;
    localparam logic [1:0] DST_LO  = 2'b01;
    localparam logic [1:0] DST_HI  = 2'b10;

    state_t            state_q, state_d;
    logic [31:0]       zh_q, zh_d;
    logic [31:0]       zl_q, zl_d;
    logic [4:0]        op_q, op_d;
    logic [RD_W-1:0]   dst_q, dst_d;
    logic              wr_en_q, wr_en_d;
    logic [1:0]        wr_dst_q, wr_dst_d;
    logic [RD_W-1:0]   wr_rd_q, wr_rd_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic              drop_q, drop_d;
    logic              done_q, done_d;
`ifdef WB_FLAGS_EN
    logic              flag_z_q, flag_z_d;
    logic              flag_n_q, flag_n_d;
`endif

    logic accept;
    logic is_gpr_op;
    logic is_pair_op;

    assign in_ready = (state_q == IDLE) |
                      (((state_q == WR_GPR) | (state_q == WR_HI)) & wr_ack);
    assign accept   = in_valid & in_ready;

    assign is_gpr_op  = ((instruction >= 5'd3) && (instruction <= 5'd14)) ||
                        (instruction == 5'd17) || (instruction == 5'd18);
    assign is_pair_op = (instruction == 5'd15) || (instruction == 5'd16);

    always_comb begin
        state_d   = state_q;
        zh_d      = zh_q;
        zl_d      = zl_q;
        op_d      = op_q;
        dst_d     = dst_q;
        drop_d    = 1'b0;
        done_d    = 1'b0;
`ifdef WB_FLAGS_EN
        flag_z_d  = flag_z_q;
        flag_n_d  = flag_n_q;
`endif

        unique case (state_q)
            IDLE: ;
            WR_GPR: begin
                if (wr_ack) begin
                    state_d  = IDLE;
                    done_d   = 1'b1;
`ifdef WB_FLAGS_EN
                    flag_z_d = (zl_q == 32'd0);
                    flag_n_d = zl_q[31];
`endif
                end
            end
            WR_LO: begin
                if (wr_ack) state_d = WR_HI;
            end
            WR_HI: begin
                if (wr_ack) begin
                    state_d  = IDLE;
                    done_d   = 1'b1;
`ifdef WB_FLAGS_EN
                    flag_z_d = ({zh_q, zl_q} == 64'd0);
                    flag_n_d = zh_q[31];
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        // A new result may land in the same cycle the old one finishes.
        if (accept) begin
            zh_d  = Z_high;
            zl_d  = Z_low;
            op_d  = instruction;
            dst_d = rd;
            if (is_gpr_op) begin
                state_d = WR_GPR;
            end else if (is_pair_op) begin
                state_d = WR_LO;
            end else begin
                state_d = IDLE;
                drop_d  = 1'b1;
            end
        end

        wr_en_d   = 1'b0;
        wr_dst_d  = DST_GPR;
        wr_rd_d   = '0;
        wr_data_d = 32'd0;
        unique case (state_d)
            IDLE: ;
            WR_GPR: begin
                wr_en_d   = 1'b1;
                wr_dst_d  = DST_GPR;
                wr_rd_d   = dst_d;
                wr_data_d = zl_d;
            end
            WR_LO: begin
                wr_en_d   = 1'b1;
                wr_dst_d  = DST_LO;
                wr_data_d = zl_d;
            end
            WR_HI: begin
                wr_en_d   = 1'b1;
                wr_dst_d  = DST_HI;
                wr_data_d = zh_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= IDLE;
            zh_q      <= 32'd0;
            zl_q      <= 32'd0;
            op_q      <= 5'd0;
            dst_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_dst_q  <= DST_GPR;
            wr_rd_q   <= '0;
            wr_data_q <= 32'd0;
            drop_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef WB_FLAGS_EN
            flag_z_q  <= 1'b0;
            flag_n_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            zh_q      <= zh_d;
            zl_q      <= zl_d;
            op_q      <= op_d;
            dst_q     <= dst_d;
            wr_en_q   <= wr_en_d;
            wr_dst_q  <= wr_dst_d;
            wr_rd_q   <= wr_rd_d;
            wr_data_q <= wr_data_d;
            drop_q    <= drop_d;
            done_q    <= done_d;
`ifdef WB_FLAGS_EN
            flag_z_q  <= flag_z_d;
            flag_n_q  <= flag_n_d;
`endif
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_dst  = wr_dst_q;
    assign wr_rd   = wr_rd_q;
    assign wr_data = wr_data_q;
    assign drop    = drop_q;
    assign done    = done_q;
`ifdef WB_FLAGS_EN
    assign flag_z  = flag_z_q;
    assign flag_n  = flag_n_q;
`endif

endmodule
